// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: input FIFO with edge-triggered capture plus a single-word output register.
// Optional blocking behaviour (CPU stall on empty read / busy write) is enabled by defining IO_BLOCKING_EN.
module io_bus_ctrl #(
    parameter int IN_DEPTH = 4,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    input  logic [1:0]        is_ready,
    input  logic [31:0]       data_input,
    output logic [31:0]       data_output,
    output logic              out_valid
);

    localparam int PTR_W = $clog2(IN_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(IN_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [1:0] REG_IN_STATUS  = 2'd0;
    localparam logic [1:0] REG_IN_DATA    = 2'd1;
    localparam logic [1:0] REG_OUT_STATUS = 2'd2;
    localparam logic [1:0] REG_OUT_DATA   = 2'd3;

    typedef enum logic { OUT_IDLE = 1'b0, OUT_BUSY = 1'b1 } out_state_t;
    typedef enum logic { IN_RUN = 1'b0, IN_WAIT = 1'b1 } in_state_t;

    logic [31:0]      mem_r [IN_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             edge_prev_r;
    logic             overflow_r;
    logic             drop_r;
    logic [31:0]      data_output_r;
    out_state_t       out_state_r;
    out_state_t       out_state_nxt_s;

    logic [1:0] sel_s;
    logic       wr_s;
    logic       rd_s;
    logic       rd_in_s;
    logic       wr_out_s;
    logic       empty_s;
    logic       full_s;
    logic       push_s;
    logic       push_ok_s;
    logic       pop_s;
    logic       load_out_s;
    logic       drop_set_s;
    logic       stall_in_s;
    logic       stall_out_s;
    logic       addr_unused_s;

    // Only addr[3:2] selects a register; the remaining bits are don't-care.
    assign addr_unused_s = ^{addr[ADDR_W-1:4], addr[1:0]};

    assign sel_s    = addr[3:2];
    assign wr_s     = we;
    assign rd_s     = re & ~we;
    assign rd_in_s  = rd_s & (sel_s == REG_IN_DATA);
    assign wr_out_s = wr_s & (sel_s == REG_OUT_DATA);

    assign empty_s   = (count_r == '0);
    assign full_s    = (count_r == FULL_CNT);
    assign push_s    = is_ready[0] & ~edge_prev_r;
    assign push_ok_s = push_s & ~full_s;
    assign pop_s     = rd_in_s & ~empty_s;

    assign out_valid   = (out_state_r == OUT_BUSY);
    assign data_output = data_output_r;
    assign stall       = stall_in_s | stall_out_s;

`ifdef IO_BLOCKING_EN
    in_state_t in_state_r;
    in_state_t in_state_nxt_s;

    // Input FSM: hold the CPU in IN_WAIT until the FIFO has a word to return.
    always_comb begin
        in_state_nxt_s = in_state_r;
        stall_in_s     = 1'b0;
        case (in_state_r)
            IN_RUN: begin
                if (rd_in_s && empty_s) begin
                    stall_in_s     = 1'b1;
                    in_state_nxt_s = IN_WAIT;
                end else begin
                    in_state_nxt_s = IN_RUN;
                end
            end
            IN_WAIT: begin
                if (empty_s) begin
                    stall_in_s     = 1'b1;
                    in_state_nxt_s = IN_WAIT;
                end else begin
                    in_state_nxt_s = IN_RUN;
                end
            end
            default: begin
                in_state_nxt_s = IN_RUN;
            end
        endcase
    end

    // Input FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_r <= IN_RUN;
        end else begin
            in_state_r <= in_state_nxt_s;
        end
    end
`else
    assign stall_in_s = 1'b0;
`endif

    // Output FSM: load on write when idle; a write while busy stalls or is dropped depending on build.
    always_comb begin
        out_state_nxt_s = out_state_r;
        load_out_s      = 1'b0;
        drop_set_s      = 1'b0;
        stall_out_s     = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                if (wr_out_s) begin
                    load_out_s      = 1'b1;
                    out_state_nxt_s = OUT_BUSY;
                end else begin
                    out_state_nxt_s = OUT_IDLE;
                end
            end
            OUT_BUSY: begin
                if (is_ready[1]) begin
                    out_state_nxt_s = OUT_IDLE;
                end else begin
                    out_state_nxt_s = OUT_BUSY;
                end
                if (wr_out_s) begin
`ifdef IO_BLOCKING_EN
                    stall_out_s = 1'b1;
`else
                    drop_set_s  = 1'b1;
`endif
                end else begin
                    stall_out_s = 1'b0;
                end
            end
            default: begin
                out_state_nxt_s = OUT_IDLE;
            end
        endcase
    end

    // CPU read mux; IN_DATA on an empty FIFO reads as zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (sel_s)
            REG_IN_STATUS:  rdata = {30'h0, overflow_r, ~empty_s};
            REG_IN_DATA:    rdata = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r];
            REG_OUT_STATUS: rdata = {30'h0, drop_r, out_valid};
            REG_OUT_DATA:   rdata = data_output_r;
            default:        rdata = 32'h0000_0000;
        endcase
    end

    // Input capture edge detector, FIFO storage/pointers and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_prev_r <= 1'b0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            for (int i = 0; i < IN_DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            edge_prev_r <= is_ready[0];
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= data_input;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // A new overflow in the clearing cycle wins so no loss goes unreported.
            if (push_s && full_s) begin
                overflow_r <= 1'b1;
            end else if (wr_s && (sel_s == REG_IN_STATUS)) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Output state, output word and drop flag; reset abandons any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_r   <= OUT_IDLE;
            data_output_r <= 32'h0000_0000;
            drop_r        <= 1'b0;
        end else begin
            out_state_r <= out_state_nxt_s;
            if (load_out_s) begin
                data_output_r <= wdata;
            end
            if (drop_set_s) begin
                drop_r <= 1'b1;
            end else if (wr_s && (sel_s == REG_OUT_STATUS)) begin
                drop_r <= 1'b0;
            end
        end
    end

endmodule
